// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional macro HAZARD_FWD_EN selects the load-use-only hazard check.
package pipe_ctrl_pkg;

  localparam int SB_DEPTH = 3;
  // Scoreboard destinations are stored zero-extended; supports REG_ADDR_W up to 8.
  localparam int SB_DST_W = 8;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic                valid;
    logic [SB_DST_W-1:0] dst;
    logic                is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dst: {SB_DST_W{1'b0}}, is_load: 1'b0};

  function automatic logic src_hit(input logic [SB_DST_W-1:0] src,
                                   input logic                used,
                                   input sb_entry_t           ent);
    return used & ent.valid & (src == ent.dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// In-flight destination scoreboard (EXE, MEM, WB slots) with RAW match logic.
// HAZARD_FWD_EN reduces the match to a load-use check on the EXE slot.
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  insert_en,
  input  logic [REG_ADDR_W-1:0] ins_dst,
  input  logic                  ins_is_load,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] src1_addr,
  input  logic [REG_ADDR_W-1:0] src2_addr,
  input  logic [REG_ADDR_W-1:0] src3_addr,
  input  logic [2:0]            src_used,
  output logic                  hazard
);

  sb_entry_t           sb_r [SB_DEPTH];
  logic [SB_DST_W-1:0] src_ext_s [3];
  logic                hit_any_s;

  // Shift register: sb_r[0]=EXE, sb_r[1]=MEM, sb_r[2]=WB; a non-insert loads a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SB_DEPTH; k++) begin
        sb_r[k] <= SB_EMPTY;
      end
    end else begin
      for (int k = SB_DEPTH - 1; k > 0; k--) begin
        sb_r[k] <= sb_r[k-1];
      end
      sb_r[0] <= insert_en ? '{valid: 1'b1, dst: SB_DST_W'(ins_dst), is_load: ins_is_load}
                           : SB_EMPTY;
    end
  end

  // Source-versus-slot match
  always_comb begin
    src_ext_s[0] = SB_DST_W'(src1_addr);
    src_ext_s[1] = SB_DST_W'(src2_addr);
    src_ext_s[2] = SB_DST_W'(src3_addr);
    hit_any_s    = 1'b0;
    for (int i = 0; i < 3; i++) begin
`ifdef HAZARD_FWD_EN
      hit_any_s = hit_any_s | (src_hit(src_ext_s[i], src_used[i], sb_r[0]) & sb_r[0].is_load);
`else
      for (int k = 0; k < SB_DEPTH; k++) begin
        hit_any_s = hit_any_s | src_hit(src_ext_s[i], src_used[i], sb_r[k]);
      end
`endif
    end
  end

  assign hazard = id_valid & hit_any_s;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller: RAW stalls, branch flush FSM, stall counter.
// Build option HAZARD_FWD_EN (see hazard_scoreboard) assumes EXE/MEM forwarding.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ARQ          = 16,
  parameter int REG_ADDR_W   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1_addr,
  input  logic [REG_ADDR_W-1:0] id_src2_addr,
  input  logic [REG_ADDR_W-1:0] id_src3_addr,
  input  logic [2:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0] id_dst_addr,
  input  logic                  id_wb_en,
  input  logic                  id_is_load,
  input  logic                  branch_taken,
  output logic                  pc_en,
  output logic                  ifid_stop,
  output logic                  ifid_flush,
  output logic                  idexe_bubble,
  output logic [ARQ-1:0]        stall_count
);

  localparam int             CNT_W        = 3;
  localparam logic           FLUSH_MULTI  = (FLUSH_CYCLES > 1) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] FLUSH_RELOAD =
    (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : {CNT_W{1'b0}};
  localparam logic [ARQ-1:0] STALL_MAX    = {ARQ{1'b1}};

  hz_state_t        state_r, state_nxt_s;
  logic [CNT_W-1:0] flush_cnt_r, flush_cnt_nxt_s;
  logic [ARQ-1:0]   stall_count_r;
  logic             hazard_s, flush_now_s, insert_en_s, stall_inc_s;

  assign flush_now_s = branch_taken | (state_r == FLUSH);
  assign insert_en_s = id_valid & id_wb_en & ~hazard_s & ~flush_now_s;

  hazard_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .insert_en   (insert_en_s),
    .ins_dst     (id_dst_addr),
    .ins_is_load (id_is_load),
    .id_valid    (id_valid),
    .src1_addr   (id_src1_addr),
    .src2_addr   (id_src2_addr),
    .src3_addr   (id_src3_addr),
    .src_used    (id_src_used),
    .hazard      (hazard_s)
  );

  // State, flush counter and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RUN;
      flush_cnt_r   <= {CNT_W{1'b0}};
      stall_count_r <= {ARQ{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      if (stall_inc_s && (stall_count_r != STALL_MAX)) begin
        stall_count_r <= stall_count_r + {{(ARQ-1){1'b0}}, 1'b1};
      end
    end
  end

  // Flush sequencing; a branch inside FLUSH restarts the window
  always_comb begin
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    case (state_r)
      RUN: begin
        if (branch_taken && FLUSH_MULTI) begin
          state_nxt_s     = FLUSH;
          flush_cnt_nxt_s = FLUSH_RELOAD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        if (branch_taken) begin
          flush_cnt_nxt_s = FLUSH_RELOAD;
        end else if (flush_cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = RUN;
        end else begin
          flush_cnt_nxt_s = flush_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s     = RUN;
        flush_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Control decode: reset, then flush, then stall
  always_comb begin
    pc_en        = 1'b1;
    ifid_stop    = 1'b0;
    ifid_flush   = 1'b0;
    idexe_bubble = 1'b0;
    stall_inc_s  = 1'b0;
    if (rst) begin
      pc_en        = 1'b0;
      ifid_flush   = 1'b1;
      idexe_bubble = 1'b1;
    end else if (flush_now_s) begin
      ifid_flush   = 1'b1;
      idexe_bubble = 1'b1;
    end else if (hazard_s) begin
      pc_en        = 1'b0;
      ifid_stop    = 1'b1;
      idexe_bubble = 1'b1;
      stall_inc_s  = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  assign stall_count = stall_count_r;

endmodule
